// File: rtl/shift_stim_gen.sv
// shift_stim_gen: load/shift stimulus sequencer driving v, d and sel of the shift stage
module shift_stim_gen #(
  parameter int          RUN_CYCLES = 8,
  parameter int          NUM_ITERS  = 0,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic        sys_clk,
  input  logic        ck_rst,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] v,
  output logic [4:0]  d,
  output logic        sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] iter_cnt
);
  localparam logic [31:0] SEED   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  localparam logic [7:0]  CNT_LD = 8'(RUN_CYCLES - 1);
  localparam logic [15:0] LIMIT  = 16'(NUM_ITERS);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] lfsr, lfsr_step;
  logic [7:0]  cnt;
  logic [15:0] iter_nx;
  logic        stop_pend, last, fin;
  always_comb begin
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
    iter_nx   = (iter_cnt == 16'hFFFF) ? iter_cnt : iter_cnt + 16'd1;
    last      = (state == RUN) && (cnt == 8'd0);
    fin       = stop_pend || ((LIMIT != 16'd0) && (iter_nx == LIMIT));
    state_nx  = (state == IDLE) ? (start ? LOAD : IDLE) :
                (state == LOAD) ? RUN :
                (state == RUN)  ? (!last ? RUN : fin ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge sys_clk or negedge ck_rst)
    if (!ck_rst) state <= IDLE;
    else         state <= state_nx;
  always_ff @(posedge sys_clk or negedge ck_rst) begin
    if (!ck_rst) begin
      v         <= 32'h0;
      d         <= 5'd0;
      sel       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      iter_cnt  <= 16'd0;
      lfsr      <= SEED;
      stop_pend <= 1'b0;
      cnt       <= 8'd0;
    end else begin
      sel       <= state_nx == LOAD;
      busy      <= (state_nx == LOAD) || (state_nx == RUN);
      done      <= state_nx == DONE;
      stop_pend <= (state == DONE) ? 1'b0 : stop_pend | (stop & ((state != IDLE) | start));
      cnt       <= (state == LOAD) ? CNT_LD : (state == RUN) ? cnt - 8'd1 : cnt;
      if (state == IDLE && start) begin
        lfsr     <= SEED;
        v        <= SEED;
        d        <= 5'd0;
        iter_cnt <= 16'd0;
      end
      if (last) begin
        lfsr     <= lfsr_step;
        d        <= d + 5'd1;
        iter_cnt <= iter_nx;
        if (state_nx == LOAD) v <= lfsr_step;
      end
    end
  end
endmodule
